// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - requester command/response and APB master signal bundle
// slave modport is the arbiter side; master modport is the requesters plus the APB completer.
interface apb_req_arbiter_if #(
    parameter int APB_AW = 32,
    parameter int APB_DW = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [APB_AW-1:0]     req0_addr;
    logic                  req0_write;
    logic [APB_DW-1:0]     req0_wdata;
    logic [APB_DW/8-1:0]   req0_strb;
    logic                  rsp0_valid;
    logic [APB_DW-1:0]     rsp0_rdata;
    logic                  rsp0_err;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [APB_AW-1:0]     req1_addr;
    logic                  req1_write;
    logic [APB_DW-1:0]     req1_wdata;
    logic [APB_DW/8-1:0]   req1_strb;
    logic                  rsp1_valid;
    logic [APB_DW-1:0]     rsp1_rdata;
    logic                  rsp1_err;

    logic [APB_AW-1:0]     m_paddr;
    logic                  m_psel;
    logic                  m_penable;
    logic                  m_pwrite;
    logic [APB_DW-1:0]     m_pwdata;
    logic [APB_DW/8-1:0]   m_pstrb;
    logic                  m_pready;
    logic [APB_DW-1:0]     m_prdata;

    modport slave (
        input  req0_valid, req0_addr, req0_write, req0_wdata, req0_strb,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_addr, req1_write, req1_wdata, req1_strb,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output m_paddr, m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb,
        input  m_pready, m_prdata
    );

    modport master (
        output req0_valid, req0_addr, req0_write, req0_wdata, req0_strb,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_addr, req1_write, req1_wdata, req1_strb,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  m_paddr, m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb,
        output m_pready, m_prdata
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - two-requester round-robin front-end onto one APB master port
// Optional ACCESS-phase timeout enabled by macro APB_REQ_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int APB_AW      = 32,
    parameter int APB_DW      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             pclk,
    input  logic             prst_n,
    apb_req_arbiter_if.slave bus
);
    localparam int SW = APB_DW / 8;

    if (TIMEOUT_CYC < 1 || (APB_DW % 8) != 0) begin : g_cfg_check
        $error("apb_req_arbiter: TIMEOUT_CYC must be >= 1 and APB_DW a multiple of 8");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t            state_q, state_d;
    logic              rr_q;
    logic              gnt_q;
    logic              win_valid;
    logic              win_id;
    logic              xfer_ok;
    logic              tmo_hit;
    logic [APB_AW-1:0] sel_addr;
    logic              sel_write;
    logic [APB_DW-1:0] sel_wdata;
    logic [SW-1:0]     sel_strb;
    logic [APB_DW-1:0] rsp_data;

    logic [APB_AW-1:0] paddr_q;
    logic              pwrite_q;
    logic [APB_DW-1:0] pwdata_q;
    logic [SW-1:0]     pstrb_q;
    logic              rsp0_valid_q, rsp1_valid_q;
    logic [APB_DW-1:0] rsp0_rdata_q, rsp1_rdata_q;

    // rr_q names the requester that wins a tie, i.e. the one not granted last.
    always_comb begin
        win_valid = prst_n && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
        win_id    = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
        sel_addr  = win_id ? bus.req1_addr  : bus.req0_addr;
        sel_write = win_id ? bus.req1_write : bus.req0_write;
        sel_wdata = win_id ? bus.req1_wdata : bus.req0_wdata;
        sel_strb  = win_id ? bus.req1_strb  : bus.req0_strb;
        rsp_data  = (xfer_ok && !pwrite_q) ? bus.m_prdata : '0;
    end

    always_comb begin
        state_d = state_q;
        xfer_ok = 1'b0;
        case (state_q)
            IDLE:    if (win_valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (bus.m_pready) begin
                    xfer_ok = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            gnt_q        <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            if (win_valid) begin
                gnt_q    <= win_id;
                rr_q     <= ~win_id;
                paddr_q  <= sel_addr;
                pwrite_q <= sel_write;
                pwdata_q <= sel_write ? sel_wdata : '0;
                pstrb_q  <= sel_write ? sel_strb  : '0;
            end
            if (xfer_ok || tmo_hit) begin
                if (gnt_q) begin
                    rsp1_valid_q <= 1'b1;
                    rsp1_rdata_q <= rsp_data;
                end else begin
                    rsp0_valid_q <= 1'b1;
                    rsp0_rdata_q <= rsp_data;
                end
            end
        end
    end

`ifdef APB_REQ_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_cnt_q;
    logic          rsp0_err_q, rsp1_err_q;

    // pready in the limit cycle wins, so the limit only fires on a stalled cycle.
    assign tmo_hit = (state_q == ACCESS) && !bus.m_pready && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge pclk) begin
        if (!prst_n) begin
            tmo_cnt_q  <= '0;
            rsp0_err_q <= 1'b0;
            rsp1_err_q <= 1'b0;
        end else begin
            if (win_valid) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ACCESS && !bus.m_pready) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (xfer_ok || tmo_hit) begin
                if (gnt_q) rsp1_err_q <= tmo_hit;
                else       rsp0_err_q <= tmo_hit;
            end
        end
    end

    assign bus.rsp0_err = rsp0_err_q;
    assign bus.rsp1_err = rsp1_err_q;
`else
    assign tmo_hit      = 1'b0;
    assign bus.rsp0_err = 1'b0;
    assign bus.rsp1_err = 1'b0;
`endif

    assign bus.req0_ready = win_valid && !win_id;
    assign bus.req1_ready = win_valid && win_id;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
    assign bus.m_psel     = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.m_penable  = (state_q == ACCESS);
    assign bus.m_paddr    = paddr_q;
    assign bus.m_pwrite   = pwrite_q;
    assign bus.m_pwdata   = pwdata_q;
    assign bus.m_pstrb    = pstrb_q;
endmodule
